// File: rtl/output_vc_allocator.sv
// Output-VC allocator for one output port: binds round-robin-selected head-flit
// requesters to the lowest free output VC, tracks downstream credits, flags misuse.
module output_vc_allocator #(
  parameter int NUM_REQ   = 20,
  parameter int V         = 4,
  parameter int BUF_DEPTH = 4,
  parameter int RW        = $clog2(NUM_REQ),
  parameter int VW        = $clog2(V),
  parameter int CW        = $clog2(BUF_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [V-1:0]       flit_sent,
  input  logic [V-1:0]       tail_sent,
  input  logic [V-1:0]       credit_upd,
  output logic [NUM_REQ-1:0] grant,
  output logic [VW-1:0]      grant_vc,
  output logic               grant_valid,
  output logic [V*RW-1:0]    vc_owner,
  output logic [V-1:0]       out_vc_available,
  output logic [V-1:0]       out_vc_ready,
  output logic               err
);

  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic                   grant_valid_q, grant_valid_d;
  logic [VW-1:0]          grant_vc_q, grant_vc_d;
  logic [V*RW-1:0]        vc_owner_q, vc_owner_d;
  logic [V-1:0]           busy_q, busy_d;
  logic [RW-1:0]          ptr_q, ptr_d;
  logic [V-1:0][CW-1:0]   cnt_q, cnt_d;
  logic                   err_q, err_d;

  logic [NUM_REQ-1:0]     eligible;
  logic                   vc_found, req_found, alloc;
  logic [VW-1:0]          vc_sel;
  logic [RW-1:0]          winner;
  logic [RW-1:0]          idx_r;
  int                     idx;

  always_comb begin
    // Last cycle's winner is masked while it is still dropping req.
    eligible = req & ~grant_q;

    vc_found = 1'b0;
    vc_sel   = '0;
    for (int v = V - 1; v >= 0; v--) begin
      if (!busy_q[v]) begin
        vc_found = 1'b1;
        vc_sel   = VW'(v);
      end
    end

    req_found = 1'b0;
    winner    = '0;
    idx       = 0;
    idx_r     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_r = RW'(idx);
      if (!req_found && eligible[idx_r]) begin
        req_found = 1'b1;
        winner    = idx_r;
      end
    end

    alloc         = vc_found && req_found;
    grant_d       = '0;
    grant_valid_d = alloc;
    grant_vc_d    = grant_vc_q;
    vc_owner_d    = vc_owner_q;
    ptr_d         = ptr_q;
    // Release cannot collide with allocation: one only touches busy VCs, the other idle ones.
    busy_d        = busy_q & ~tail_sent;
    if (alloc) begin
      grant_d[winner]                       = 1'b1;
      grant_vc_d                            = vc_sel;
      vc_owner_d[int'(vc_sel) * RW +: RW]   = winner;
      busy_d[vc_sel]                        = 1'b1;
      ptr_d = (winner == RW'(NUM_REQ - 1)) ? '0 : winner + RW'(1);
    end

    err_d = err_q;
    cnt_d = cnt_q;
    for (int v = 0; v < V; v++) begin
      if (flit_sent[v] && !credit_upd[v]) begin
        if (cnt_q[v] == '0) err_d = 1'b1;
        else                cnt_d[v] = cnt_q[v] - CW'(1);
      end else if (credit_upd[v] && !flit_sent[v]) begin
        if (cnt_q[v] == CW'(BUF_DEPTH)) err_d = 1'b1;
        else                            cnt_d[v] = cnt_q[v] + CW'(1);
      end
      if ((flit_sent[v] || tail_sent[v]) && !busy_q[v]) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_vc_q    <= '0;
      vc_owner_q    <= '0;
      busy_q        <= '0;
      ptr_q         <= '0;
      cnt_q         <= {V{CW'(BUF_DEPTH)}};
      err_q         <= 1'b0;
    end else begin
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      grant_vc_q    <= grant_vc_d;
      vc_owner_q    <= vc_owner_d;
      busy_q        <= busy_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      err_q         <= err_d;
    end
  end

  always_comb begin
    out_vc_ready = '0;
    for (int v = 0; v < V; v++) out_vc_ready[v] = (cnt_q[v] != '0);
  end

  assign grant            = grant_q;
  assign grant_valid      = grant_valid_q;
  assign grant_vc         = grant_vc_q;
  assign vc_owner         = vc_owner_q;
  assign out_vc_available = ~busy_q;
  assign err              = err_q;

endmodule
